// File: rtl/line_delay_ctrl.sv
// Line-delay controller: pairs each pixel with the pixel in the same
// column of the previous line, using an external one-line sync FIFO.
module line_delay_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int MAX_WIDTH  = 2048,
  parameter int CW         = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof,
  input  logic [CW-1:0]         line_width,
  input  logic                  pix_vld,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_cur,
  output logic [DATA_WIDTH-1:0] out_prev,
  output logic                  out_prev_vld,
  output logic                  out_eol,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam logic [CW-1:0] MAXW = CW'(MAX_WIDTH);

  state_t                r_state;
  state_t                w_nxt;
  state_t                w_mode;
  logic [CW-1:0]         r_width;
  logic [CW-1:0]         r_col;
  logic                  r_err;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_cur;
  logic                  r_out_pv;
  logic                  r_out_eol;

  logic                  w_wid_bad;
  logic [CW-1:0]         w_new_wid;
  logic                  w_go_flush;
  logic [CW-1:0]         w_col;
  logic [CW-1:0]         w_wid;
  logic [CW-1:0]         w_col_nxt;
  logic                  w_acc;
  logic                  w_wrap;
  logic                  w_rd_req;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_err_set;

  assign w_wid_bad = (line_width == '0) || (line_width > MAXW);
  assign w_new_wid = (line_width == '0) ? CW'(1)
                   : (line_width > MAXW) ? MAXW
                   : line_width;

  // sof re-targets the current cycle so a same-cycle pixel joins the new frame
  assign w_go_flush = sof && (r_state != S_IDLE) && !fifo_empty;
  assign w_mode = !sof      ? r_state
                : w_go_flush ? S_FLUSH
                : S_FILL;
  assign w_col = sof ? '0 : r_col;
  assign w_wid = sof ? w_new_wid : r_width;

  assign w_acc  = pix_vld && (w_mode == S_FILL || w_mode == S_RUN);
  assign w_wrap = w_acc && (w_col == w_wid - CW'(1));
  assign w_col_nxt = !w_acc ? w_col
                   : w_wrap ? '0
                   : w_col + CW'(1);

  assign w_rd_req = (w_acc && w_mode == S_RUN)
                 || (r_state == S_FLUSH && w_mode == S_FLUSH && !fifo_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    if (sof) begin
      w_nxt = w_go_flush ? S_FLUSH : (w_wrap ? S_RUN : S_FILL);
    end else begin
      case (r_state)
        S_IDLE:  w_nxt = S_IDLE;
        S_FILL:  w_nxt = w_wrap ? S_RUN : S_FILL;
        S_RUN:   w_nxt = S_RUN;
        S_FLUSH: w_nxt = fifo_empty ? S_FILL : S_FLUSH;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // A paired read frees a slot, so full only blocks an unpaired write
  always_comb begin
    w_rd = rst_n && w_rd_req && !fifo_empty;
    w_wr = rst_n && w_acc && (!fifo_full || w_rd);
    w_err_set = (sof && w_wid_bad)
             || (pix_vld && w_mode == S_FLUSH)
             || (w_acc && fifo_full && !w_rd)
             || (w_rd_req && fifo_empty);
  end

  assign fifo_wr_en   = w_wr;
  assign fifo_wr_data = pix_data;
  assign fifo_rd_en   = w_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width   <= MAXW;
      r_col     <= '0;
      r_err     <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_cur <= '0;
      r_out_pv  <= 1'b0;
      r_out_eol <= 1'b0;
    end else begin
      if (sof) begin
        r_width <= w_new_wid;
      end
      r_col     <= w_col_nxt;
      r_err     <= (r_err && !sof) || w_err_set;
      r_out_vld <= w_acc;
      if (w_acc) begin
        r_out_cur <= pix_data;
      end
      r_out_pv  <= w_acc && (w_mode == S_RUN);
      r_out_eol <= w_wrap;
    end
  end

  assign out_vld      = r_out_vld;
  assign out_cur      = r_out_cur;
  assign out_prev     = r_out_pv ? fifo_rd_data : '0;
  assign out_prev_vld = r_out_pv;
  assign out_eol      = r_out_eol;
  assign err          = r_err;

endmodule
